traffic_signal: RTL and testbench
=================================

Name: traffic_signal

Overview:
- Two-road (East-West / North-South) traffic light controller driven by a free-running 4-bit step counter Q.
- Lamp outputs are a Moore decode of Q: the first half of the 16-step cycle serves EW, the second half serves NS.
- Switch enables cycling. With Switch low, the controller finishes the current cycle and parks at step 0 (EW green).
- Standalone leaf block. Q is exported for display/debug.

Parameters:
- GREEN_STEPS, 6, green steps per direction per half-cycle; legal 1..7. Yellow steps = 8 - GREEN_STEPS.
- SET_VALUE, 4'hF, value loaded into Q when Setn is asserted.

Ports:
- Clock  input  1  system clock; all state changes on rising edge
- Resetn  input  1  synchronous reset, active-low; Q <= 0
- Setn  input  1  synchronous preset, active-low; Q <= SET_VALUE
- Switch  input  1  run enable; 1 = cycle continuously, 0 = park at Q=0
- Q  output  4  current step counter
- EW_G  output  1  East-West green lamp
- EW_Y  output  1  East-West yellow lamp
- EW_R  output  1  East-West red lamp
- NS_G  output  1  North-South green lamp
- NS_Y  output  1  North-South yellow lamp
- NS_R  output  1  North-South red lamp

Behaviour:
- Single register: Q[3:0]. All lamps are combinational decodes of Q; no other state.
- Update priority on each rising Clock edge:
  - Resetn=0 -> Q <= 0.
  - else Setn=0 -> Q <= SET_VALUE.
  - else Switch=1 -> Q <= Q+1, wrapping mod 16 (15 -> 0).
  - else Switch=0 and Q!=0 -> Q <= Q+1 (drain to the end of the cycle, wraps to 0).
  - else Switch=0 and Q==0 -> Q holds 0.
- Decode, with G = GREEN_STEPS:
  - Q in [0, G-1]: EW_G=1, NS_R=1.
  - Q in [G, 7]: EW_Y=1, NS_R=1.
  - Q in [8, 8+G-1]: NS_G=1, EW_R=1.
  - Q in [8+G, 15]: NS_Y=1, EW_R=1.
  - All other lamps are 0.
- Invariants:
  - Exactly one lamp per direction is on, every cycle.
  - Never a green or yellow on both directions at once.
- After reset: Q=0, EW_G=1, NS_R=1, all other lamps 0.
- Latency: lamps change in the same cycle Q changes (zero-cycle decode of registered Q).
- Switch deassert mid-cycle: counting continues to 15 -> 0, then holds at 0. Lamps end on EW green / NS red.
- Switch reassert while parked: Q=1 on the next edge.
- Setn during park: Q loads SET_VALUE (default 15). The next edge wraps to 0 regardless of Switch.
- Reset mid-operation: Q=0 on the next edge, independent of Setn and Switch.
- Resetn and Setn low simultaneously: reset wins.

Optional Feature:
- Macro ALL_RED_EN.
- When defined:
  - Step 7 and step 15 become all-red clearance steps: EW_R=1, NS_R=1, no yellow lit.
  - The yellow ranges shrink to [G, 6] and [8+G, 14].
  - GREEN_STEPS is limited to 1..6.
- When undefined: decode exactly as in Behaviour, with no all-red step.

Test Plan:
- Reset with Switch=1: hold Resetn=0 for 1 edge -> Q=0, EW_G=1, NS_R=1, others 0. Release -> Q runs 1,2,...,15,0.
- Full cycle, default G=6, Switch=1:
  - Q=0..5: EW_G/NS_R. Q=6..7: EW_Y/NS_R.
  - Q=8..13: NS_G/EW_R. Q=14..15: NS_Y/EW_R.
  - Q=0 again on the 16th edge.
- Park: drop Switch at Q=10 -> Q continues 11..15,0 then holds 0 with EW_G=1. Raise Switch -> Q=1 on the next edge.
- Setn=0 for 1 edge at Q=3 -> Q=15 (NS_Y=1, EW_R=1). Next edge -> Q=0.
- Resetn=0 together with Setn=0 at Q=9 -> Q=0. Every cycle, check no simultaneous EW(G|Y) and NS(G|Y).
- With ALL_RED_EN: Q=7 -> EW_R=1, NS_R=1, no yellow. Q=6 -> EW_Y=1. Q=15 -> both red.

Source files
------------

// File: rtl/traffic_signal.sv
// traffic_signal: two-road (East-West / North-South) traffic light controller.
// A free-running 4-bit step counter Q sequences a 16-step cycle. Steps 0..7
// serve East-West and steps 8..15 serve North-South. The lamps are a Moore
// decode of Q. When Switch is low the controller completes the current cycle
// and then parks at step 0, which shows EW green and NS red.
//
// Optional feature: define ALL_RED_EN to turn steps 7 and 15 into all-red
// clearance steps. This shortens each yellow phase by one step and limits
// GREEN_STEPS to 1..6. When the macro is undefined, the yellow phase runs to
// the end of each half-cycle.
//
// The counter Q is the only state in the block. It is also exported so it can
// be shown on a display or used for debug.
module traffic_signal #(
    parameter int          GREEN_STEPS = 6,     // green steps per direction, 1..7 (1..6 with ALL_RED_EN)
    parameter logic [3:0]  SET_VALUE   = 4'hF   // value loaded into Q by Setn
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Setn,
    input  logic       Switch,
    output logic [3:0] Q,
    output logic       EW_G,
    output logic       EW_Y,
    output logic       EW_R,
    output logic       NS_G,
    output logic       NS_Y,
    output logic       NS_R
);

    // Green length as a 4-bit constant, for comparison against the step within a half-cycle.
    localparam logic [3:0] GREEN_LEN = 4'(GREEN_STEPS);

    // Step within the current half-cycle (0..7). Q[3] selects which road is served.
    logic [3:0] half_step;
    logic       in_green;
    logic       in_clear;

    assign half_step = {1'b0, Q[2:0]};
    assign in_green  = (half_step < GREEN_LEN);

`ifdef ALL_RED_EN
    // The last step of each half-cycle shows red on both roads.
    assign in_clear  = (Q[2:0] == 3'd7);
`else
    assign in_clear  = 1'b0;
`endif

    // Step counter. Priority is reset, then preset, then counting.
    // With Switch low, the counter keeps draining until it wraps to 0 and then holds there.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            Q <= 4'd0;
        end else if (!Setn) begin
            Q <= SET_VALUE;
        end else if (Switch || (Q != 4'd0)) begin
            Q <= Q + 4'd1;
        end
    end

    // Lamp decode. The road being served shows green and then yellow (or clearance red).
    // The other road stays red for the whole half-cycle.
    always_comb begin
        EW_G = 1'b0;
        EW_Y = 1'b0;
        EW_R = 1'b0;
        NS_G = 1'b0;
        NS_Y = 1'b0;
        NS_R = 1'b0;
        if (!Q[3]) begin
            NS_R = 1'b1;
            if (in_green) begin
                EW_G = 1'b1;
            end else if (in_clear) begin
                EW_R = 1'b1;
            end else begin
                EW_Y = 1'b1;
            end
        end else begin
            EW_R = 1'b1;
            if (in_green) begin
                NS_G = 1'b1;
            end else if (in_clear) begin
                NS_R = 1'b1;
            end else begin
                NS_Y = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_traffic_signal.sv
// tb_traffic_signal: bench for traffic_signal with the default parameters.
// A step task drives the inputs for one clock edge and computes the expected
// Q and lamps from a reference model. It pushes the expected result into a
// queue, then pops it after the edge and compares it with the DUT outputs.
// The bench follows ALL_RED_EN if the macro is defined for the build.
module tb_traffic_signal;

    localparam int         G       = 6;
    localparam logic [3:0] SET_VAL = 4'hF;

    // Clock and reset signals.
    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       Setn = 1'b1;
    logic       Switch = 1'b0;
    logic [3:0] Q;
    logic       EW_G, EW_Y, EW_R, NS_G, NS_Y, NS_R;

    always #5 Clock = ~Clock;

    traffic_signal #(.GREEN_STEPS(G), .SET_VALUE(SET_VAL)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Setn   (Setn),
        .Switch (Switch),
        .Q      (Q),
        .EW_G   (EW_G),
        .EW_Y   (EW_Y),
        .EW_R   (EW_R),
        .NS_G   (NS_G),
        .NS_Y   (NS_Y),
        .NS_R   (NS_R)
    );

    // Scoreboard state. Each queue entry packs {Q, EW_G, EW_Y, EW_R, NS_G, NS_Y, NS_R}.
    logic [9:0] exp_q[$];
    logic [3:0] m_q;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check_eq(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference lamp decode. Returns {EW_G, EW_Y, EW_R, NS_G, NS_Y, NS_R}.
    function automatic logic [5:0] model_lamps(input logic [3:0] q);
        int s;
        s = int'(q);
        if (s < G)            return 6'b100_001;
        else if (s <= 7) begin
`ifdef ALL_RED_EN
            if (s == 7)       return 6'b001_001;
`endif
                              return 6'b010_001;
        end
        else if (s < 8 + G)   return 6'b001_100;
        else begin
`ifdef ALL_RED_EN
            if (s == 15)      return 6'b001_001;
`endif
                              return 6'b001_010;
        end
    endfunction

    // Driver for one clock edge. It updates the model, pushes the expected
    // result, waits for the edge, then pops and compares.
    task automatic step(input logic rn, input logic sn, input logic sw, input string tag);
        logic [9:0] e;
        logic [5:0] lamps;
        Resetn = rn;
        Setn   = sn;
        Switch = sw;
        if (!rn)                   m_q = 4'd0;
        else if (!sn)              m_q = SET_VAL;
        else if (sw || m_q != 0)   m_q = m_q + 4'd1;
        exp_q.push_back({m_q, model_lamps(m_q)});
        @(posedge Clock);
        #1;
        e = exp_q.pop_front();
        check_eq({tag, "_q"}, {6'd0, Q}, {6'd0, e[9:6]});
        lamps = {EW_G, EW_Y, EW_R, NS_G, NS_Y, NS_R};
        check_eq({tag, "_lamps"}, {4'd0, lamps}, {4'd0, e[5:0]});
        // Never show green or yellow on both roads at once.
        check_eq({tag, "_conflict"}, {9'd0, (EW_G | EW_Y) & (NS_G | NS_Y)}, 10'd0);
    endtask

    initial begin
        m_q = 4'd0;
        @(negedge Clock);

        // Reset with Switch high.
        step(1'b0, 1'b1, 1'b1, "reset");

        // Full cycle: Q runs 1..15 and wraps back to 0.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b1, "cycle");

        // Count to Q=10, drop Switch, drain to 0 and park there.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, "to10");
        for (int i = 0; i < 6; i++)  step(1'b1, 1'b1, 1'b0, "drain");
        for (int i = 0; i < 3; i++)  step(1'b1, 1'b1, 1'b0, "park");
        step(1'b1, 1'b1, 1'b1, "unpark");

        // At Q=3, assert Setn to load 15. The next edge wraps to 0 even with Switch low.
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1, "to3");
        step(1'b1, 1'b0, 1'b1, "set");
        step(1'b1, 1'b1, 1'b0, "set_wrap");
        step(1'b1, 1'b1, 1'b0, "park2");

        // Assert Setn while parked.
        step(1'b1, 1'b0, 1'b0, "set_park");
        step(1'b1, 1'b1, 1'b0, "set_park_wrap");

        // Assert Resetn and Setn together at Q=9. Reset must win.
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b1, "to9");
        step(1'b0, 1'b0, 1'b1, "rst_set");

        // Random stimulus.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) != 0), ($urandom_range(0, 14) != 0),
                 ($urandom_range(0, 3) != 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
